daisy_readout_stage: RTL and testbench

//  One stage of the pixel-block readout daisy chain. It is the parametrised successor of the fixed 4-channel block stage.
//  - Captures CH_NUM ADC samples on each adc_ready rising edge.
//  - Forwards upstream chain words with one cycle of latency.
//  - Inserts its own samples into the chain when a token arrives from upstream.

---
 rtl/daisy_readout_stage.sv | 131 +++++++++++++
 tb/tb_daisy_readout_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/daisy_readout_stage.sv
// One stage of the pixel-block readout daisy chain: captures CH_NUM samples per adc_ready edge and
// inserts them into the chain on the upstream token. Optional ID/channel tagging: DAISY_READOUT_TAG_EN.
module daisy_readout_stage #(
  parameter  int CH_NUM   = 4,
  parameter  int DATA_W   = 12,
  parameter  int ID_W     = 6,
  parameter  int BLOCK_ID = 0,
  localparam int CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
`ifdef DAISY_READOUT_TAG_EN
  localparam int W        = DATA_W + 1 + ID_W + CH_W
`else
  localparam int W        = DATA_W + 1
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     adc_ready,
  input  logic [CH_NUM*DATA_W-1:0] adc_data,
  input  logic [W-1:0]             data_from_pre,
  input  logic                     token_in,
  input  logic                     clr_ovr,
  output logic [W-1:0]             data_to_post,
  output logic                     token_out,
  output logic                     busy,
  output logic                     overrun
);

  // Elaboration-time sanity checks; the block ID must fit its field when tagging is enabled.
  if (CH_NUM < 1 || DATA_W < 1 || ID_W < 1) begin : g_bad_width
    $error("daisy_readout_stage: CH_NUM, DATA_W and ID_W must all be >= 1");
  end
  if (BLOCK_ID < 0 || BLOCK_ID >= (1 << ID_W)) begin : g_bad_id
    $error("daisy_readout_stage: BLOCK_ID does not fit in ID_W bits");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_SEND
  } state_t;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CH_NUM - 1);

  state_t            state;
  logic [CH_W-1:0]   cnt;
  logic              adc_ready_d;
  logic              rise;
  logic              capture;
  logic [DATA_W-1:0] shadow [CH_NUM];
  logic [W-1:0]      own_word;

  assign rise    = adc_ready & ~adc_ready_d;
  assign capture = (state == S_IDLE) && rise && en;

`ifdef DAISY_READOUT_TAG_EN
  assign own_word = {1'b0, ID_W'(BLOCK_ID), cnt, shadow[cnt]};
`else
  assign own_word = {1'b0, shadow[cnt]};
`endif

  // NOTE: the shadow bank is plain storage with no reset; it is only read after a capture has filled it.
  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      for (int ch = 0; ch < CH_NUM; ch++) begin
        shadow[ch] <= adc_data[ch*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      adc_ready_d  <= 1'b1;
      data_to_post <= '1;
      token_out    <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      adc_ready_d <= adc_ready;

      // A capture edge while busy beats a simultaneous clear.
      if (rise && busy) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          data_to_post <= data_from_pre;
          token_out    <= token_in;
          if (capture) begin
            state <= S_ARMED;
            busy  <= 1'b1;
          end
        end

        S_ARMED: begin
          data_to_post <= data_from_pre;
          token_out    <= 1'b0;
          if (token_in) begin
            state <= S_SEND;
            cnt   <= '0;
          end
        end

        S_SEND: begin
          data_to_post <= own_word;
          if (cnt == LAST_CH) begin
            token_out <= 1'b1;
            cnt       <= '0;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end else begin
            token_out <= 1'b0;
            cnt       <= cnt + CH_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_daisy_readout_stage.sv
// Bench for daisy_readout_stage: a single tagged stage (BLOCK_ID=5) driven from a vector table and
// hand sequences, plus an 8-stage chain checked frame by frame against a queue-based model.
module tb_daisy_readout_stage;

  localparam int CH_NUM = 4;
  localparam int DATA_W = 12;
  localparam int ID_W   = 6;
  localparam int CH_W   = 2;
  localparam int NST    = 8;
`ifdef DAISY_READOUT_TAG_EN
  localparam int TW     = DATA_W + 1 + ID_W + CH_W;
`else
  localparam int TW     = DATA_W + 1;
`endif
  localparam logic [TW-1:0] IDLE_W = '1;

`ifdef DAISY_READOUT_TAG_EN
  `define TB_OWN(id, ch, s) {1'b0, ID_W'(id), CH_W'(ch), DATA_W'(s)}
`else
  `define TB_OWN(id, ch, s) {1'b0, DATA_W'(s)}
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // single stage
  logic                     en, adc_ready, token_in, clr_ovr;
  logic [CH_NUM*DATA_W-1:0] adc_data;
  logic [TW-1:0]            data_from_pre, data_to_post;
  logic                     token_out, busy, overrun;

  daisy_readout_stage #(.CH_NUM(CH_NUM), .DATA_W(DATA_W), .ID_W(ID_W), .BLOCK_ID(5)) dut (
    .clk(clk), .rst(rst), .en(en), .adc_ready(adc_ready), .adc_data(adc_data),
    .data_from_pre(data_from_pre), .token_in(token_in), .clr_ovr(clr_ovr),
    .data_to_post(data_to_post), .token_out(token_out), .busy(busy), .overrun(overrun)
  );

  // 8-stage chain
  logic [NST-1:0]           c_en;
  logic                     c_ready, c_token0;
  logic [CH_NUM*DATA_W-1:0] c_adc [NST];
  logic [TW-1:0]            c_out [NST];
  logic                     c_tok [NST];
  logic                     c_busy [NST];
  logic                     c_ovr [NST];

  for (genvar k = 0; k < NST; k++) begin : g_chain
    logic [TW-1:0] pre;
    logic          tin;
    if (k == 0) begin : g_first
      assign pre = IDLE_W;
      assign tin = c_token0;
    end else begin : g_next
      assign pre = c_out[k-1];
      assign tin = c_tok[k-1];
    end
    daisy_readout_stage #(.CH_NUM(CH_NUM), .DATA_W(DATA_W), .ID_W(ID_W), .BLOCK_ID(k)) u_stage (
      .clk(clk), .rst(rst), .en(c_en[k]), .adc_ready(c_ready), .adc_data(c_adc[k]),
      .data_from_pre(pre), .token_in(tin), .clr_ovr(1'b0),
      .data_to_post(c_out[k]), .token_out(c_tok[k]), .busy(c_busy[k]), .overrun(c_ovr[k])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_w(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TW-1:0] pw(input int v);
    return TW'(v);
  endfunction

  typedef struct {
    logic          rdy;
    logic          tok;
    logic [TW-1:0] pre;
    logic [TW-1:0] exp_data;
    logic          exp_tok;
    logic          exp_busy;
  } vec_t;

  vec_t tbl [19];

  // One chain frame: common capture edge, token into stage 0, collect stage 7 output until its token.
  task automatic run_frame(input string tag, input logic [NST-1:0] en_cap,
                           input logic [NST-1:0] en_after, input bit rnd);
    logic [TW-1:0] exp_q [$];
    logic [TW-1:0] got_q [$];
    logic [TW-1:0] w;
    int            gaps;
    bit            started, tok_seen;
    gaps = 0; started = 0; tok_seen = 0;

    for (int k = 0; k < NST; k++) begin
      for (int ch = 0; ch < CH_NUM; ch++) begin
        c_adc[k][ch*DATA_W +: DATA_W] = rnd ? DATA_W'($urandom()) : DATA_W'(k * 256 + ch * 16 + 1);
      end
    end
    // reference: every stage enabled at the capture edge contributes ch0..ch3, in stage order
    for (int k = 0; k < NST; k++) begin
      if (en_cap[k]) begin
        for (int ch = 0; ch < CH_NUM; ch++) begin
          exp_q.push_back(`TB_OWN(k, ch, c_adc[k][ch*DATA_W +: DATA_W]));
        end
      end
    end

    c_en = en_cap; c_ready = 1'b0; tick();
    c_ready = 1'b1; tick();
    c_ready = 1'b0; c_en = en_after; tick();
    c_token0 = 1'b1; tick();
    c_token0 = 1'b0;

    for (int cyc = 0; cyc < 300 && !tok_seen; cyc++) begin
      tick();
      w = c_out[NST-1];
      if (!w[TW-1]) begin
        started = 1;
        got_q.push_back(w);
      end else if (started) begin
        gaps++;
      end
      if (c_tok[NST-1]) tok_seen = 1;
    end

    check_b({tag, "_token_arrived"}, tok_seen, 1'b1);
    check_i({tag, "_word_count"}, got_q.size(), exp_q.size());
    check_i({tag, "_idle_gaps"}, gaps, 0);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_w($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
    end
    tick();
    for (int k = 0; k < NST; k++) begin
      check_b($sformatf("%s_busy_st%0d", tag, k), c_busy[k], 1'b0);
      check_b($sformatf("%s_ovr_st%0d", tag, k), c_ovr[k], 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0]            word2;
    logic [CH_NUM*DATA_W-1:0] a_data;
    word2 = '0;

    tbl[0]  = '{1'b0, 1'b0, pw('h0AB), pw('h0AB),                 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, pw('h0CD), pw('h0CD),                 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, pw('h111), pw('h111),                 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, pw('h122), pw('h122),                 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, pw('h133), `TB_OWN(5, 0, 12'h000),   1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, pw('h144), `TB_OWN(5, 1, 12'h010),   1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, pw('h144), `TB_OWN(5, 2, 12'h020),   1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, pw('h144), `TB_OWN(5, 3, 12'h030),   1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, pw('h155), pw('h155),                 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, pw('h166), pw('h166),                 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, IDLE_W,    IDLE_W,                    1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, pw('h0DD), pw('h0DD),                 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, pw('h0EE), pw('h0EE),                 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b0, IDLE_W,    IDLE_W,                    1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, pw('h077), pw('h077),                 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, pw('h999), `TB_OWN(5, 0, 12'h000),   1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, pw('h999), `TB_OWN(5, 1, 12'h010),   1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, pw('h999), `TB_OWN(5, 2, 12'h020),   1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, pw('h999), `TB_OWN(5, 3, 12'h030),   1'b1, 1'b0};

    rst = 1'b1; en = 1'b1; adc_ready = 1'b1; token_in = 1'b0; clr_ovr = 1'b0;
    adc_data = {12'd48, 12'd32, 12'd16, 12'd0};
    data_from_pre = IDLE_W;
    c_en = '1; c_ready = 1'b1; c_token0 = 1'b0;
    for (int k = 0; k < NST; k++) c_adc[k] = '0;

    // T1: reset with adc_ready held high
    repeat (3) tick();
    check_w("rst_data", data_to_post, IDLE_W);
    check_b("rst_token", token_out, 1'b0);
    check_b("rst_busy", busy, 1'b0);
    check_b("rst_overrun", overrun, 1'b0);
    check_w("rst_chain_data", c_out[NST-1], IDLE_W);
    rst = 1'b0;
    tick(); tick();
    check_b("rel_no_capture", busy, 1'b0);
    token_in = 1'b1; data_from_pre = pw('h05A); tick();
    check_w("rel_pass_data", data_to_post, pw('h05A));
    check_b("rel_pass_token", token_out, 1'b1);
    check_b("rel_pass_busy", busy, 1'b0);
    token_in = 1'b0; data_from_pre = IDLE_W; tick();
    check_b("rel_token_low", token_out, 1'b0);

    // T2 + same-cycle rise/token: vector table
    for (int i = 0; i < 19; i++) begin
      adc_ready = tbl[i].rdy; token_in = tbl[i].tok; data_from_pre = tbl[i].pre;
      tick();
      check_w($sformatf("vec%0d_data", i), data_to_post, tbl[i].exp_data);
      check_b($sformatf("vec%0d_token", i), token_out, tbl[i].exp_tok);
      check_b($sformatf("vec%0d_busy", i), busy, tbl[i].exp_busy);
      if (i == 6) word2 = data_to_post;
    end
`ifdef DAISY_READOUT_TAG_EN
    check_w("t6_tag_word2", word2, TW'(21'h016020));
`else
    check_w("t2_word2", word2, TW'(13'h0020));
`endif

    // T5: overrun
    adc_ready = 1'b0; token_in = 1'b0; data_from_pre = IDLE_W;
    a_data = {12'hA33, 12'hA22, 12'hA11, 12'hA00};
    adc_data = a_data; tick();
    adc_ready = 1'b1; tick();
    adc_ready = 1'b0; adc_data = {12'hB33, 12'hB22, 12'hB11, 12'hB00}; tick();
    check_b("ovr_before", overrun, 1'b0);
    adc_ready = 1'b1; tick();
    check_b("ovr_set", overrun, 1'b1);
    adc_ready = 1'b0; tick();
    adc_ready = 1'b1; clr_ovr = 1'b1; tick();
    check_b("ovr_clr_vs_rise", overrun, 1'b1);
    adc_ready = 1'b0; tick();
    check_b("ovr_cleared", overrun, 1'b0);
    clr_ovr = 1'b0;
    en = 1'b0;
    token_in = 1'b1; tick();
    token_in = 1'b0;
    for (int ch = 0; ch < CH_NUM; ch++) begin
      tick();
      check_w($sformatf("ovr_word%0d", ch), data_to_post, `TB_OWN(5, ch, a_data[ch*DATA_W +: DATA_W]));
      check_b($sformatf("ovr_tok%0d", ch), token_out, ch == CH_NUM - 1);
    end
    check_b("ovr_done_busy", busy, 1'b0);
    en = 1'b1;

    // reset in the middle of SEND abandons the frame
    tick();
    adc_ready = 1'b1; tick();
    adc_ready = 1'b0; token_in = 1'b1; tick();
    token_in = 1'b0; tick(); tick();
    rst = 1'b1; tick();
    check_w("midrst_data", data_to_post, IDLE_W);
    check_b("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (5) begin
      tick();
      check_b("midrst_no_token", token_out, 1'b0);
    end

    // T3 full chain, T4 stage 3 skipped, T4b stage enable dropped after capture, then random frames
    run_frame("t3", 8'hFF, 8'hFF, 0);
    run_frame("t4", 8'hF7, 8'hF7, 0);
    run_frame("t4b", 8'hFF, 8'h00, 0);
    for (int f = 0; f < 20; f++) begin
      run_frame($sformatf("rnd%0d", f), NST'($urandom()), NST'($urandom()), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  `undef TB_OWN

endmodule
